clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Runtime-programmable integer clock divider controller with 50% duty cycle output.
- Sequences ratio changes through a valid/ready config handshake and applies each change only at an output-period boundary, so o_clk never glitches.
- Gates the divided clock on and off cleanly. Sits between the system config bus and downstream logic that consumes the divided clock and the per-period tick.

Parameters:
- CNT_W, 8, width of divide ratio and internal period counter.
- DIV_RST, 7, divide ratio loaded at reset. Must satisfy 2 <= DIV_RST <= 2^CNT_W-1.

Ports:
- i_clk  input  1  source clock, both edges used.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  divider enable, level.
- i_cfg_valid  input  1  new ratio offered.
- i_cfg_div  input  CNT_W  offered divide ratio N.
- o_cfg_ready  output  1  controller can accept a ratio.
- o_cfg_err  output  1  one-cycle pulse: accepted ratio was invalid (N<2).
- o_div_cur  output  CNT_W  ratio currently in effect.
- o_busy  output  1  divider running (state != IDLE).
- o_tick  output  1  one-cycle pulse in the first i_clk cycle of each output period.
- o_clk  output  1  divided clock.

Behaviour:
- One clock; reset is asynchronous and active-high (i_clk, i_rst).
- Reset values (asserted asynchronously, including mid-operation):
  - state=IDLE, cnt=0.
  - o_clk=0, forced low immediately, including any negedge-path flop.
  - o_div_cur=DIV_RST, o_cfg_ready=1, o_cfg_err=0, o_busy=0, o_tick=0.
  - pending register cleared.
- States:
  - IDLE: o_clk=0, cnt=0.
  - RUN: dividing, no pending ratio.
  - PEND: dividing, one accepted ratio waiting for a boundary.
  - STOP: i_en dropped, finishing the current period.
- Transitions:
  - IDLE to RUN on the posedge with i_en=1. That edge is cnt=0: o_clk rises, o_tick=1.
  - RUN to PEND on a valid accept, unless the accept lands on a boundary (below).
  - PEND to RUN at a boundary.
  - RUN or PEND to STOP when i_en=0. A pending ratio is retained.
  - STOP to IDLE at the boundary. STOP returns to RUN/PEND if i_en=1 again before the boundary.
- Counter: cnt counts 0..N_cur-1 and wraps. The boundary is the posedge ending the cnt==N_cur-1 cycle.
- Waveform for N_cur = N:
  - o_clk rises on the posedge entering cnt=0.
  - Even N: o_clk falls on the posedge entering cnt=N/2.
  - Odd N: o_clk falls on the negedge inside cycle cnt=(N-1)/2.
  - High time is exactly N/2 source periods; period is N source periods.
- Handshake:
  - Transfer occurs when i_cfg_valid & o_cfg_ready at a posedge.
  - o_cfg_ready=0 only in PEND, or in STOP with a pending ratio.
  - i_cfg_div is sampled only on transfer.
- Apply rules:
  - IDLE accept: o_div_cur updates the next cycle.
  - Accept on the boundary cycle (cnt==N_cur-1): bypass pending. The new ratio governs the period that starts at that wrap.
  - Otherwise: applied at the next boundary. o_div_cur changes on that same edge.
- Invalid ratio (N=0 or 1):
  - Handshake still completes.
  - o_cfg_err=1 for the cycle after the transfer.
  - No state change, o_div_cur unchanged.
- Disable: the current period completes with full high and low times, then o_clk stays 0. Leaving STOP emits no o_tick.
- o_tick asserts during cycle cnt=0 of every period in RUN/PEND/STOP, including the first period after IDLE.
- Ratio boundary values: N=2 gives a toggle every cycle. N=2^CNT_W-1 must not overflow the counter.

Test Plan:
- Reset, i_en=1, no cfg, DIV_RST=7 -> o_clk period 7 i_clk, high 3.5 cycles, o_tick every 7 cycles, o_busy=1.
- Running N=7, accept N=4 at cnt=2 -> current period finishes at 7 cycles; next periods are 4 cycles, high 2. o_div_cur changes 7->4 at the boundary. o_cfg_ready low from the accept until the boundary.
- Running N=4, accept N=3 exactly at cnt=3 -> next period is already 3 cycles, high 1.5. o_cfg_ready never drops.
- Offer N=1, then N=0 -> each completes the handshake, o_cfg_err pulses once each, o_div_cur and o_clk are undisturbed.
- N=5, drop i_en at cnt=1 -> period completes (high 2.5, total 5), then o_clk=0, o_busy=0. Re-raise i_en -> o_clk rises on the next posedge with o_tick=1.
- Assert i_rst while o_clk=1 mid-period at N=9, after a pending ratio was accepted -> o_clk=0 immediately, o_div_cur=7, pending discarded, o_cfg_ready=1.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - runtime-programmable 50% duty integer clock divider controller
//
// Purpose:
//   Divides i_clk by a programmable ratio N (2..2^CNT_W-1) with a 50% duty
//   cycle. Odd ratios use a negedge flop to move the falling edge half a
//   source cycle. Ratio changes are taken over a valid/ready handshake and
//   only applied at an output-period boundary, so o_clk never glitches.
//
// Ports:
//   i_clk        source clock (both edges used)
//   i_rst        asynchronous active-high reset
//   i_en         divider enable (level)
//   i_cfg_valid  new ratio offered
//   i_cfg_div    offered ratio N
//   o_cfg_ready  controller can accept a ratio
//   o_cfg_err    one-cycle pulse after an accepted ratio below 2
//   o_div_cur    ratio currently in effect
//   o_busy       divider running (not IDLE)
//   o_tick       pulse during the first i_clk cycle of each output period
//   o_clk        divided clock

module clk_div_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_cfg_valid,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    output logic [CNT_W-1:0] o_div_cur,
    output logic             o_busy,
    output logic             o_tick,
    output logic             o_clk
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_err_q, cfg_err_d;
    logic             clk_pos_q, clk_pos_d;
    logic             clk_neg_q;

    logic             active;
    logic             boundary;
    logic             cfg_ready;
    logic             xfer;
    logic             ratio_ok;
    logic [CNT_W:0]   half_d;

    assign active    = (state_q != IDLE);
    // Last cycle of the current output period; the next posedge starts a new one.
    assign boundary  = active && (cnt_q == (div_q - ONE));
    // A second ratio cannot be held while one is already waiting.
    assign cfg_ready = !((state_q == PEND) || ((state_q == STOP) && pend_vld_q));
    assign xfer      = i_cfg_valid && cfg_ready;
    assign ratio_ok  = (i_cfg_div >= TWO);

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_RST_V;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            clk_pos_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_err_d;
            clk_pos_q  <= clk_pos_d;
        end
    end

    // Odd ratios: mask the high phase from the middle of cycle (N-1)/2 until the
    // middle of the next cycle, by which time clk_pos_q has already dropped.
    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_neg_q <= 1'b0;
        end else begin
            clk_neg_q <= active && div_q[0] && (cnt_q == (div_q >> 1));
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cfg_err_d  = xfer && !ratio_ok;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer && ratio_ok) begin
                    div_d = i_cfg_div;
                end
                if (i_en) begin
                    state_d = RUN;
                end
            end
            default: begin
                cnt_d = boundary ? '0 : (cnt_q + ONE);
                if (boundary) begin
                    // An accept on the boundary bypasses the pending slot; ready
                    // is low whenever the slot is full, so the two never collide.
                    if (xfer && ratio_ok) begin
                        div_d = i_cfg_div;
                    end else if (pend_vld_q) begin
                        div_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
                end else if (xfer && ratio_ok) begin
                    pend_d     = i_cfg_div;
                    pend_vld_d = 1'b1;
                end

                if (!i_en) begin
                    state_d = boundary ? IDLE : STOP;
                end else begin
                    state_d = pend_vld_d ? PEND : RUN;
                end
            end
        endcase

        // High for the first ceil(N/2) cycles; extra bit keeps N=2^CNT_W-1 safe.
        half_d    = ({1'b0, div_d} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
        clk_pos_d = (state_d != IDLE) && ({1'b0, cnt_d} < half_d);
    end

    // Outputs
    always_comb begin
        o_cfg_ready = cfg_ready;
        o_cfg_err   = cfg_err_q;
        o_div_cur   = div_q;
        o_busy      = active;
        o_tick      = active && (cnt_q == '0);
        o_clk       = clk_pos_q & ~clk_neg_q;
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl

module tb_clk_div_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic [7:0] div_cur;
    logic       busy;
    logic       tick;
    logic       oclk;

    int checks;
    int failures;

    clk_div_ctrl #(.CNT_W(8), .DIV_RST(7)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_cfg_valid (cfg_valid),
        .i_cfg_div   (cfg_div),
        .o_cfg_ready (cfg_ready),
        .o_cfg_err   (cfg_err),
        .o_div_cur   (div_cur),
        .o_busy      (busy),
        .o_tick      (tick),
        .o_clk       (oclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Entered #1 after a posedge in cycle c of a period of ratio n; checks both
    // halves of the cycle and returns #1 after the next posedge.
    task automatic check_cycle(input int n, input int c);
        check_eq($sformatf("div_cur n=%0d c=%0d", n, c), div_cur, n);
        check_eq($sformatf("busy n=%0d c=%0d", n, c), busy, 1);
        check_eq($sformatf("tick n=%0d c=%0d", n, c), tick, (c == 0) ? 1 : 0);
        check_eq($sformatf("clk_h1 n=%0d c=%0d", n, c), oclk, (c < (n + 1) / 2) ? 1 : 0);
        @(negedge clk); #1;
        check_eq($sformatf("clk_h2 n=%0d c=%0d", n, c), oclk, (c < n / 2) ? 1 : 0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " clk"}, oclk, 0);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " tick"}, tick, 0);
        @(negedge clk); #1;
        check_eq({tag, " clk_h2"}, oclk, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst clk", oclk, 0);
        check_eq("rst div_cur", div_cur, 7);
        check_eq("rst ready", cfg_ready, 1);
        check_eq("rst err", cfg_err, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst tick", tick, 0);

        // Default ratio 7, two periods
        rst = 1'b0;
        en  = 1'b1;
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 7; c++) check_cycle(7, c);

        // Accept 4 at cnt=2: applied at the next boundary
        check_cycle(7, 0);
        check_cycle(7, 1);
        check_eq("n4 ready pre", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd4;
        check_cycle(7, 2);
        cfg_valid = 1'b0;
        for (int c = 3; c < 7; c++) begin
            check_eq($sformatf("n4 ready pend c=%0d", c), cfg_ready, 0);
            check_cycle(7, c);
        end
        check_eq("n4 ready post", cfg_ready, 1);
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) check_cycle(4, c);

        // Accept 3 on the boundary cycle: bypasses pending
        for (int c = 0; c < 3; c++) check_cycle(4, c);
        cfg_valid = 1'b1;
        cfg_div   = 8'd3;
        check_eq("n3 ready", cfg_ready, 1);
        check_cycle(4, 3);
        cfg_valid = 1'b0;
        check_eq("n3 ready after", cfg_ready, 1);
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 3; c++) check_cycle(3, c);

        // Invalid ratios 1 and 0
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        check_cycle(3, 0);
        cfg_valid = 1'b0;
        check_eq("err n1 pulse", cfg_err, 1);
        check_cycle(3, 1);
        check_eq("err n1 clear", cfg_err, 0);
        cfg_valid = 1'b1;
        cfg_div   = 8'd0;
        check_cycle(3, 2);
        cfg_valid = 1'b0;
        check_eq("err n0 pulse", cfg_err, 1);
        check_eq("err n0 ready", cfg_ready, 1);
        check_cycle(3, 0);
        check_eq("err n0 clear", cfg_err, 0);
        check_cycle(3, 1);
        check_cycle(3, 2);

        // Switch to 5 on the boundary, then disable at cnt=1
        check_cycle(3, 0);
        check_cycle(3, 1);
        cfg_valid = 1'b1;
        cfg_div   = 8'd5;
        check_cycle(3, 2);
        cfg_valid = 1'b0;
        check_cycle(5, 0);
        en = 1'b0;
        for (int c = 1; c < 5; c++) check_cycle(5, c);
        check_idle("stop idle0");
        check_idle("stop idle1");

        // Re-enable: first posedge starts a period with a tick
        en = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) check_cycle(5, c);
        cfg_valid = 1'b1;
        cfg_div   = 8'd2;
        check_cycle(5, 4);
        cfg_valid = 1'b0;

        // N=2, then maximum ratio 255
        check_cycle(2, 0);
        check_cycle(2, 1);
        check_cycle(2, 0);
        cfg_valid = 1'b1;
        cfg_div   = 8'd255;
        check_cycle(2, 1);
        cfg_valid = 1'b0;
        for (int c = 0; c < 254; c++) check_cycle(255, c);
        cfg_valid = 1'b1;
        cfg_div   = 8'd9;
        check_cycle(255, 254);
        cfg_valid = 1'b0;

        // N=9 with a pending ratio, then reset while o_clk is high
        check_cycle(9, 0);
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        check_cycle(9, 1);
        cfg_valid = 1'b0;
        check_eq("n9 ready pend", cfg_ready, 0);
        check_cycle(9, 2);
        check_cycle(9, 3);
        check_eq("pre-rst clk high", oclk, 1);
        rst = 1'b1;
        #1;
        check_eq("midrst clk", oclk, 0);
        check_eq("midrst div_cur", div_cur, 7);
        check_eq("midrst ready", cfg_ready, 1);
        check_eq("midrst busy", busy, 0);
        check_eq("midrst tick", tick, 0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 7; c++) check_cycle(7, c);
        check_eq("post-rst div_cur", div_cur, 7);
        check_eq("post-rst ready", cfg_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
